// File: rtl/srt_div_ctrl.sv
// srt_div_ctrl: sequencing controller for a radix-2 SRT divider datapath.
// Loads operands, steps WIDTH recurrence iterations while converting the
// signed digit stream to binary on the fly (Q / QM pair), applies the final
// negative-remainder correction and pulses done with the quotient.
// Optional build macro: SRT_DIV_CTRL_ERR_EN enables the sticky invalid-digit
// flag on err; without it err is tied low.
module srt_div_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic [1:0]       est_q,
  input  logic             rem_neg,
  output logic             load,
  output logic             shift_en,
  output logic             fixing,
  output logic [1:0]       pre_p_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CORRECT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qm_r;
  logic [CW-1:0]    cnt;
  logic [1:0]       dig_r;
  logic             accept;

  // A digit is consumed on every non-stalled ITER cycle.
  assign accept = (state == S_ITER) && !hold;

  // Sequencer plus on-the-fly conversion registers and final quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      q_r   <= '0;
      qm_r  <= '0;
      cnt   <= '0;
      dig_r <= '0;
      q_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          q_r   <= '0;
          qm_r  <= '0;
          cnt   <= '0;
          dig_r <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          if (!hold) begin
            dig_r <= est_q;
            case (est_q)
              2'b10: begin
                q_r  <= {q_r[WIDTH-2:0], 1'b1};
                qm_r <= {q_r[WIDTH-2:0], 1'b0};
              end
              2'b01: begin
                q_r  <= {qm_r[WIDTH-2:0], 1'b1};
                qm_r <= {qm_r[WIDTH-2:0], 1'b0};
              end
              default: begin
                // zero digit; the invalid code 2'b11 is folded in here
                q_r  <= {q_r[WIDTH-2:0], 1'b0};
                qm_r <= {qm_r[WIDTH-2:0], 1'b1};
              end
            endcase
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= S_CORRECT;
          end
        end
        S_CORRECT: begin
          q_out <= rem_neg ? qm_r : q_r;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Phase outputs decoded straight from the state register.
  always_comb begin
    load = (state == S_LOAD);
    busy = (state == S_LOAD) || (state == S_ITER) || (state == S_CORRECT);
    done = (state == S_DONE);
  end

  // Selection-block override: released only while a digit is being accepted;
  // during a stall it replays the last captured digit, otherwise forces zero.
  always_comb begin
    shift_en    = accept;
    fixing      = !accept;
    pre_p_value = 2'b00;
    if ((state == S_ITER) && hold) pre_p_value = dig_r;
  end

`ifdef SRT_DIV_CTRL_ERR_EN
  logic err_r;

  // Sticky invalid-digit flag, cleared when a new division loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (state == S_LOAD) begin
      err_r <= 1'b0;
    end else if (accept && (est_q == 2'b11)) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_srt_div_ctrl.sv
// Testbench for srt_div_ctrl (WIDTH=4): table-driven directed divisions,
// a reset-abort sequence and randomized divisions checked against an
// arithmetic model of the quotient (sum of signed digit weights mod 2^W).
module tb_srt_div_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         hold = 1'b0;
  logic [1:0]   est_q = 2'b00;
  logic         rem_neg = 1'b0;
  logic         load;
  logic         shift_en;
  logic         fixing;
  logic [1:0]   pre_p_value;
  logic         busy;
  logic         done;
  logic [W-1:0] q_out;
  logic         err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic        err_m = 1'b0;

  typedef struct {
    logic [1:0]   d [W];
    logic [15:0]  hmask;
    logic         rn;
    logic         noisy;
    logic [W-1:0] exp_q;
    logic         has_exp;
  } vec_t;

  localparam int unsigned NV = 9;
  vec_t tab [NV];

  srt_div_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hold       (hold),
    .est_q      (est_q),
    .rem_neg    (rem_neg),
    .load       (load),
    .shift_en   (shift_en),
    .fixing     (fixing),
    .pre_p_value(pre_p_value),
    .busy       (busy),
    .done       (done),
    .q_out      (q_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] ds, input logic [15:0] hm, input logic rn,
                              input logic noisy, input logic [W-1:0] eq);
    vec_t v;
    for (int i = 0; i < int'(W); i++) v.d[i] = ds[2*(int'(W)-1-i) +: 2];
    v.hmask = hm;
    v.rn = rn;
    v.noisy = noisy;
    v.exp_q = eq;
    v.has_exp = 1'b1;
    return v;
  endfunction

  // flags packed as {load, busy, shift_en, fixing, done}
  function automatic logic [31:0] flags();
    return 32'({load, busy, shift_en, fixing, done});
  endfunction

  task automatic run_div(input vec_t v, input string tag);
    int unsigned t;
    int unsigned acc;
    int          val;
    logic [1:0]  last;
    logic [1:0]  dg;
    logic [W-1:0] model_q;
    // IDLE cycle: request (also checks the previous DONE did not re-trigger)
    start = 1'b1; hold = 1'($urandom); est_q = 2'($urandom); rem_neg = 1'($urandom);
    #1;
    chk({tag, ".idle_flags"}, flags(), 32'b00010);
    chk({tag, ".idle_pre"}, 32'(pre_p_value), 32'd0);
    chk({tag, ".idle_err"}, 32'(err), 32'(err_m));
    tick();
    // LOAD
    start = v.noisy; hold = 1'($urandom); est_q = 2'($urandom);
    #1;
    chk({tag, ".load_flags"}, flags(), 32'b11010);
    chk({tag, ".load_pre"}, 32'(pre_p_value), 32'd0);
    chk({tag, ".load_err"}, 32'(err), 32'(err_m));
    tick();
    err_m = 1'b0;
    // ITER
    t = 0; acc = 0; val = 0; last = 2'b00;
    while (acc < W && t < 16) begin
      hold  = v.hmask[t];
      est_q = hold ? 2'($urandom) : v.d[acc];
      start = v.noisy;
      #1;
      chk({tag, ".iter_flags"}, flags(), 32'({1'b0, 1'b1, !hold, hold, 1'b0}));
      if (hold) chk({tag, ".hold_pre"}, 32'(pre_p_value), 32'(last));
      chk({tag, ".iter_err"}, 32'(err), 32'(err_m));
      tick();
      if (!hold) begin
        dg = v.d[acc];
        last = dg;
        if (dg == 2'b10) val += (1 << (W - 1 - acc));
        else if (dg == 2'b01) val -= (1 << (W - 1 - acc));
`ifdef SRT_DIV_CTRL_ERR_EN
        if (dg == 2'b11) err_m = 1'b1;
`endif
        acc++;
      end
      t++;
    end
    if (acc < W) chk({tag, ".iter_budget"}, 32'(acc), 32'(W));
    // CORRECT
    rem_neg = v.rn; hold = 1'($urandom); est_q = 2'($urandom); start = v.noisy;
    #1;
    chk({tag, ".corr_flags"}, flags(), 32'b01010);
    chk({tag, ".corr_pre"}, 32'(pre_p_value), 32'd0);
    tick();
    // DONE
    rem_neg = ~v.rn; start = v.noisy;
    #1;
    model_q = W'(val - int'(v.rn));
    chk({tag, ".done_flags"}, flags(), 32'b00011);
    chk({tag, ".q_model"}, 32'(q_out), 32'(model_q));
    if (v.has_exp) chk({tag, ".q_table"}, 32'(q_out), 32'(v.exp_q));
    chk({tag, ".done_err"}, 32'(err), 32'(err_m));
    tick();
    start = 1'b0;
  endtask

  initial begin
    vec_t rv;
    tab[0] = mk(8'b10_00_01_10, 16'h0000, 1'b0, 1'b0, 4'b0111);
    tab[1] = mk(8'b10_00_01_10, 16'h0000, 1'b1, 1'b1, 4'b0110);
    tab[2] = mk(8'b00_00_00_00, 16'h0000, 1'b0, 1'b0, 4'b0000);
    tab[3] = mk(8'b10_01_00_10, 16'h000C, 1'b0, 1'b0, 4'b0101);
    tab[4] = mk(8'b01_00_00_00, 16'h0000, 1'b0, 1'b0, 4'b1000);
    tab[5] = mk(8'b01_01_01_01, 16'h0000, 1'b1, 1'b0, 4'b0000);
    tab[6] = mk(8'b10_10_10_10, 16'h0000, 1'b0, 1'b1, 4'b1111);
    tab[7] = mk(8'b10_11_00_00, 16'h0000, 1'b1, 1'b0, 4'b0111);
    tab[8] = mk(8'b10_01_00_10, 16'h0000, 1'b0, 1'b0, 4'b0101);

    // reset values while rst_n is held low
    #3;
    chk("rst_flags", flags(), 32'b00010);
    chk("rst_pre", 32'(pre_p_value), 32'd0);
    chk("rst_q", 32'(q_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #9 rst_n = 1'b1;
    tick();

    for (int i = 0; i < int'(NV); i++) run_div(tab[i], $sformatf("vec%0d", i));

    // reset asserted in the third ITER cycle aborts without done
    start = 1'b1; #1; tick(); start = 1'b0;
    hold = 1'b0; est_q = 2'b10; tick();
    est_q = 2'b01; tick();
    est_q = 2'b10; tick();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_flags", flags(), 32'b00010);
    chk("abort_pre", 32'(pre_p_value), 32'd0);
    chk("abort_q", 32'(q_out), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    err_m = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < int'(W) + 6; i++) begin
      chk("abort_no_done", 32'({busy, done}), 32'd0);
      tick();
    end
    run_div(tab[0], "post_abort");

    // randomized divisions against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < int'(W); i++) rv.d[i] = 2'($urandom);
      rv.hmask   = 16'($urandom & $urandom & $urandom);
      rv.rn      = 1'($urandom);
      rv.noisy   = 1'($urandom);
      rv.exp_q   = '0;
      rv.has_exp = 1'b0;
      run_div(rv, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
